writeback_stage: RTL and testbench

Back end of the scalar pipeline: consumes the per-instruction write-back controls produced by `decoderStage` (`RegWriteEn`, `RegToWrite`, `WriteRegFrom`, `Immediate`) together with the ALU result and synchronous data-memory read data. It carries them through a MEM and a WB pipeline register, selects the write-back value, and commits it to a 16×16-bit register file. It also serves the decoder's two register read ports with WB bypass, and raises a read-after-write hazard/stall toward fetch/decode.

---
 rtl/asip_pkg.sv | 39 +++
 rtl/writeback_stage_regfile.sv | 31 +++
 rtl/writeback_stage.sv | 100 ++++++++++
 tb/tb_writeback_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/asip_pkg.sv
// Shared types for the scalar pipeline back end: write-back source select,
// datapath widths and the MEM pipeline register layout.
package asip_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_MEM    = 2'd1,
    WB_IMM    = 2'd2,
    WB_IMM_HI = 2'd3
  } wb_sel_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] rd;
    wb_sel_t           wsel;
    logic [7:0]        imm;
    logic [DATA_W-1:0] alu;
  } mem_stage_t;

  function automatic logic [DATA_W-1:0] wb_select(input wb_sel_t sel,
                                                  input logic [DATA_W-1:0] alu,
                                                  input logic [DATA_W-1:0] rdata,
                                                  input logic [7:0] imm);
    logic [DATA_W-1:0] res;
    case (sel)
      WB_ALU:    res = alu;
      WB_MEM:    res = rdata;
      WB_IMM:    res = {8'h00, imm};
      WB_IMM_HI: res = {imm, 8'h00};
      default:   res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/writeback_stage_regfile.sv
// 16x16 register file: one synchronous write port, two combinational read
// ports, r0 hardwired to zero; synchronous reset clears every entry.
module regfile_16x16 #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_a,
  output logic [DATA_W-1:0]        rdata_b
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/writeback_stage.sv
// MEM + WB pipeline registers, write-back select and register commit; commit
// two cycles after issue. Never stalls itself: hazard asks decode to bubble.
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic                     ex_reg_we,
  input  logic [$clog2(NREGS)-1:0] ex_rd,
  input  logic [1:0]               ex_wsel,
  input  logic [7:0]               ex_imm,
  input  logic [DATA_W-1:0]        ex_alu,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        ReadData,
  input  logic [$clog2(NREGS)-1:0] rs_a,
  input  logic [$clog2(NREGS)-1:0] rs_b,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic                     hazard,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [DATA_W-1:0]        wb_data
);
  import asip_pkg::*;

  localparam int AW = $clog2(NREGS);

  mem_stage_t        mem_q, mem_d;
  logic              wb_valid_q, wb_valid_d;
  logic [AW-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] arr_a, arr_b;

  always_comb begin
    mem_d       = '0;
    mem_d.valid = ex_valid & ~flush;
    mem_d.we    = ex_reg_we;
    mem_d.rd    = ex_rd;
    mem_d.wsel  = wb_sel_t'(ex_wsel);
    mem_d.imm   = ex_imm;
    mem_d.alu   = ex_alu;
  end

  // ReadData belongs to the instruction currently in MEM, so select here.
  always_comb begin
    wb_valid_d = mem_q.valid & mem_q.we;
    wb_rd_d    = mem_q.rd;
    wb_data_d  = wb_select(mem_q.wsel, mem_q.alu, ReadData, mem_q.imm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  regfile_16x16 #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_valid_q),
    .waddr   (wb_rd_q),
    .wdata   (wb_data_q),
    .raddr_a (rs_a),
    .raddr_b (rs_b),
    .rdata_a (arr_a),
    .rdata_b (arr_b)
  );

  function automatic logic [DATA_W-1:0] rd_port(input logic [AW-1:0] rs,
                                                input logic [DATA_W-1:0] arr);
    if (rs == '0)                          return '0;
    else if (wb_valid_q && wb_rd_q == rs)  return wb_data_q;
    else                                   return arr;
  endfunction

  // WB is covered by bypass, so only EX input and MEM can raise a hazard.
  function automatic logic dep(input logic [AW-1:0] rs);
    return (rs != '0) &&
           ((ex_valid && ex_reg_we && !flush && ex_rd == rs) ||
            (mem_q.valid && mem_q.we && mem_q.rd == rs));
  endfunction

  assign rd_data_a = rd_port(rs_a, arr_a);
  assign rd_data_b = rd_port(rs_b, arr_b);
  assign hazard    = dep(rs_a) | dep(rs_b);
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: hand-computed values, checked #1 after
// inputs settle, mid-cycle between rising edges.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_we, flush;
  logic [3:0]  ex_rd, rs_a, rs_b, wb_rd;
  logic [1:0]  ex_wsel;
  logic [7:0]  ex_imm;
  logic [15:0] ex_alu, ReadData, rd_data_a, rd_data_b, wb_data;
  logic        hazard, wb_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_reg_we(ex_reg_we), .ex_rd(ex_rd),
    .ex_wsel(ex_wsel), .ex_imm(ex_imm), .ex_alu(ex_alu),
    .flush(flush), .ReadData(ReadData),
    .rs_a(rs_a), .rs_b(rs_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .hazard(hazard), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ex_valid = 0; ex_reg_we = 0; ex_rd = 0; ex_wsel = 0;
    ex_imm = 0; ex_alu = 0; flush = 0;
  endtask

  task automatic issue(input logic [3:0] rd, input logic [1:0] wsel,
                       input logic [7:0] imm, input logic [15:0] alu);
    ex_valid = 1; ex_reg_we = 1; ex_rd = rd; ex_wsel = wsel;
    ex_imm = imm; ex_alu = alu; flush = 0;
  endtask

  initial begin
    idle();
    rst = 1; ReadData = 16'h0; rs_a = 4'd3; rs_b = 4'd5;
    ex_valid = 1; ex_reg_we = 1; ex_rd = 4'd3; ex_alu = 16'h7777;
    step(); step();
    idle();
    #1;
    chk("rst_wb_valid", {31'b0, wb_valid}, 0);
    chk("rst_wb_rd", {28'b0, wb_rd}, 0);
    chk("rst_wb_data", {16'b0, wb_data}, 0);
    chk("rst_hazard", {31'b0, hazard}, 0);
    chk("rst_rd_a", {16'b0, rd_data_a}, 0);
    rst = 0;

    // ALU write r3 <- 1234
    step();
    issue(4'd3, 2'd0, 8'h00, 16'h1234); rs_a = 4'd3; rs_b = 4'd0; #1;
    chk("alu_haz_N", {31'b0, hazard}, 1);
    step(); idle(); #1;
    chk("alu_haz_N1", {31'b0, hazard}, 1);
    chk("alu_wbv_N1", {31'b0, wb_valid}, 0);
    step(); #1;
    chk("alu_wbv_N2", {31'b0, wb_valid}, 1);
    chk("alu_wbrd_N2", {28'b0, wb_rd}, 3);
    chk("alu_wbdat_N2", {16'b0, wb_data}, 16'h1234);
    chk("alu_byp_N2", {16'b0, rd_data_a}, 16'h1234);
    chk("alu_haz_N2", {31'b0, hazard}, 0);
    step(); #1;
    chk("alu_wbv_N3", {31'b0, wb_valid}, 0);
    chk("alu_arr_N3", {16'b0, rd_data_a}, 16'h1234);

    // Load r5 from ReadData in N+1
    issue(4'd5, 2'd1, 8'h00, 16'h1111); rs_a = 4'd0; rs_b = 4'd5; #1;
    chk("ld_haz_N", {31'b0, hazard}, 1);
    step(); idle(); ReadData = 16'hBEEF; #1;
    chk("ld_haz_N1", {31'b0, hazard}, 1);
    step(); ReadData = 16'h0; #1;
    chk("ld_haz_N2", {31'b0, hazard}, 0);
    chk("ld_wbdat_N2", {16'b0, wb_data}, 16'hBEEF);
    chk("ld_byp_N2", {16'b0, rd_data_b}, 16'hBEEF);
    step(); #1;
    chk("ld_arr_N3", {16'b0, rd_data_b}, 16'hBEEF);

    // Immediates: r1 <- 00A5, r2 <- A500
    issue(4'd1, 2'd2, 8'hA5, 16'h2222); rs_a = 4'd0; rs_b = 4'd0;
    step(); issue(4'd2, 2'd3, 8'hA5, 16'h3333);
    step(); idle(); #1;
    chk("imm_lo_wb", {16'b0, wb_data}, 16'h00A5);
    step(); #1;
    chk("imm_hi_wb", {16'b0, wb_data}, 16'hA500);
    step(); rs_a = 4'd1; rs_b = 4'd2; #1;
    chk("imm_r1", {16'b0, rd_data_a}, 16'h00A5);
    chk("imm_r2", {16'b0, rd_data_b}, 16'hA500);

    // Write to r0: committed but dropped, never a hazard
    issue(4'd0, 2'd0, 8'h00, 16'hFFFF); rs_a = 4'd0; rs_b = 4'd0; #1;
    chk("r0_haz_N", {31'b0, hazard}, 0);
    step(); idle(); #1;
    chk("r0_haz_N1", {31'b0, hazard}, 0);
    step(); #1;
    chk("r0_wbv_N2", {31'b0, wb_valid}, 1);
    chk("r0_wbrd_N2", {28'b0, wb_rd}, 0);
    chk("r0_rd_N2", {16'b0, rd_data_a}, 0);
    step(); #1;
    chk("r0_rd_N3", {16'b0, rd_data_a}, 0);

    // Flushed r4 write and a we=0 bubble to r6
    issue(4'd4, 2'd0, 8'h00, 16'h4444); flush = 1; rs_a = 4'd4; rs_b = 4'd6; #1;
    chk("fl_haz_N", {31'b0, hazard}, 0);
    step(); issue(4'd6, 2'd0, 8'h00, 16'h6666); ex_reg_we = 0; #1;
    chk("fl_haz_N1", {31'b0, hazard}, 0);
    step(); idle(); #1;
    chk("fl_wbv_N2", {31'b0, wb_valid}, 0);
    step(); #1;
    chk("bub_wbv", {31'b0, wb_valid}, 0);
    chk("fl_r4", {16'b0, rd_data_a}, 0);
    chk("bub_r6", {16'b0, rd_data_b}, 0);

    // Back-to-back writes to r7
    issue(4'd7, 2'd0, 8'h00, 16'h0001); rs_a = 4'd7; rs_b = 4'd0;
    step(); issue(4'd7, 2'd0, 8'h00, 16'h0002);
    step(); idle(); #1;
    chk("r7_N2", {16'b0, rd_data_a}, 16'h0001);
    step(); #1;
    chk("r7_N3", {16'b0, rd_data_a}, 16'h0002);
    step(); #1;
    chk("r7_N4", {16'b0, rd_data_a}, 16'h0002);
    step(); #1;
    chk("r7_N5", {16'b0, rd_data_a}, 16'h0002);

    // Reset while r9 write sits in MEM
    issue(4'd9, 2'd0, 8'h00, 16'hABCD); rs_a = 4'd3; rs_b = 4'd9;
    step(); idle(); rst = 1;
    step(); rst = 0; #1;
    chk("rm_wbv", {31'b0, wb_valid}, 0);
    chk("rm_wbrd", {28'b0, wb_rd}, 0);
    chk("rm_wbdat", {16'b0, wb_data}, 0);
    chk("rm_haz", {31'b0, hazard}, 0);
    chk("rm_r3", {16'b0, rd_data_a}, 0);
    chk("rm_r9", {16'b0, rd_data_b}, 0);
    step(); rs_a = 4'd7; #1;
    chk("rm_wbv_next", {31'b0, wb_valid}, 0);
    chk("rm_r9_next", {16'b0, rd_data_b}, 0);
    chk("rm_r7", {16'b0, rd_data_a}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
